// File: rtl/sipo_frame_rx.sv
`default_nettype none
// sipo_frame_rx: start/data/parity/stop serial frame receiver with a one-word
// valid/ready output stage. Reception keeps running while a word waits for the consumer.
module sipo_frame_rx #(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int LSB_FIRST  = 1
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             SER_IN,
   input  logic             BIT_EN,
   input  logic             RDY,
   output logic [WIDTH-1:0] DATA,
   output logic             VALID,
   output logic             PAR_ERR,
   output logic             FRM_ERR,
   output logic             OVR,
   output logic             BUSY
);
   localparam int   CW      = $clog2(WIDTH + 1);
   localparam logic ODD_BIT = PARITY_ODD[0];

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [WIDTH-1:0] shift_reg, shift_nxt, shifted;
   logic             par_err_q, par_err_nxt;
   logic             stop_strobe;
   logic             load, drop, xfer;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         par_err_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift_reg <= shift_nxt;
         par_err_q <= par_err_nxt;
      end
   end

   // Shifting the whole register keeps WIDTH=1 legal in both bit orders.
   always_comb begin
      if (LSB_FIRST != 0) begin
         shifted            = shift_reg >> 1;
         shifted[WIDTH-1]   = SER_IN;
      end else begin
         shifted            = shift_reg << 1;
         shifted[0]         = SER_IN;
      end
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift_reg;
      par_err_nxt = par_err_q;
      stop_strobe = 1'b0;
      if (BIT_EN) begin
         case (state)
            IDLE: begin
               if (!SER_IN) begin
                  state_nxt   = RX_DATA;
                  bit_cnt_nxt = '0;
               end
            end
            RX_DATA: begin
               shift_nxt   = shifted;
               bit_cnt_nxt = bit_cnt + CW'(1);
               if (bit_cnt == CW'(WIDTH - 1))
                  state_nxt = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
               par_err_nxt = ((^shift_reg) ^ SER_IN) != ODD_BIT;
               state_nxt   = RX_STOP;
            end
            RX_STOP: begin
               // A low stop bit is a framing error only; no resync on it.
               stop_strobe = 1'b1;
               state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign xfer = VALID && RDY;
   assign load = stop_strobe && (!VALID || RDY);
   assign drop = stop_strobe && VALID && !RDY;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         DATA    <= '0;
         VALID   <= 1'b0;
         PAR_ERR <= 1'b0;
         FRM_ERR <= 1'b0;
         OVR     <= 1'b0;
      end else begin
         if (load) begin
            DATA    <= shift_reg;
            PAR_ERR <= (PARITY_EN != 0) ? par_err_q : 1'b0;
            FRM_ERR <= ~SER_IN;
            VALID   <= 1'b1;
         end else if (xfer) begin
            VALID   <= 1'b0;
         end
         if (drop)
            OVR <= 1'b1;
         else if (xfer)
            OVR <= 1'b0;
      end
   end

   assign BUSY = (state != IDLE);
endmodule
`default_nettype wire
